// File: rtl/instr_fetch.sv
// Single-issue instruction fetch stage: PC, instruction-memory request, held instruction, next-PC select.
// Define FETCH_PERF_CNT_EN to build the accepted/redirected instruction counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        Jump,
    input  logic        BEQ,
    input  logic        BNE,
    input  logic        Zero,
    output logic [31:0] instr_count,
    output logic [31:0] redirect_count
);

    // Bit 0 is the memory request and bit 1 the valid flag, so both outputs come straight off a flop.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } state_t;

    state_t      state, state_nxt;
    logic        fetch_done;
    logic        accept;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic        br_taken;

    assign fetch_done = (state == FETCH) && imem_ack;
    assign accept     = (state == HOLD) && instr_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (imem_ack) state_nxt = HOLD;
            HOLD:    if (instr_ready) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = state[0];
        instr_valid = state[1];
    end

    assign pc_plus4    = pc + 32'd4;
    assign br_offset   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_target   = pc_plus4 + br_offset;
    assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign br_taken    = (BEQ && Zero) || (BNE && !Zero);

    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        if (Jump) begin
            next_pc  = jump_target;
            redirect = 1'b1;
        end else if (br_taken) begin
            next_pc  = br_target;
            redirect = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            if (fetch_done) instr <= imem_rdata;
            if (accept)     pc    <= next_pc;
        end
    end

    assign imem_addr = pc;
    assign opcode    = instr[31:26];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count    <= '0;
            redirect_count <= '0;
        end else if (accept) begin
            instr_count <= instr_count + 32'd1;
            if (redirect) redirect_count <= redirect_count + 32'd1;
        end
    end
`else
    assign instr_count    = '0;
    assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed program with literal expectations, then randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_instr_fetch;

    localparam int N_DIR  = 16;
    localparam int RAND_N = 250;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        Jump = 1'b0;
    logic        BEQ = 1'b0;
    logic        BNE = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] instr_count;
    logic [31:0] redirect_count;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .opcode         (opcode),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .Jump           (Jump),
        .BEQ            (BEQ),
        .BNE            (BNE),
        .Zero           (Zero),
        .instr_count    (instr_count),
        .redirect_count (redirect_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Directed program: per fetch index, the word returned, memory latency, ready delay and {Jump,BEQ,BNE,Zero}.
    logic [31:0] exp_addr [N_DIR] = '{
        32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C,
        32'h0000_0010, 32'h0000_0010, 32'h0000_0014, 32'h0000_0010,
        32'h0000_0020, 32'h0000_0040, 32'h0000_0044, 32'hFFFF_FFF4,
        32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000
    };
    logic [31:0] data_s [N_DIR];
    int          lat_s  [N_DIR];
    int          rdy_s  [N_DIR];
    logic [3:0]  rd_s   [N_DIR];

    int          cyc = 0;
    int          n_fetch = 0;
    int          wait_cnt = 0;
    int          hold_cnt = 0;
    bit          force_ack = 1'b0;
    logic [31:0] fetch_addr [$];
    int          fetch_cyc  [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory and consumer driver: inputs change only on the falling edge.
    always @(negedge clk) begin
        int idx;
        if (!rst_n) begin
            imem_ack    = force_ack;
            imem_rdata  = $urandom;
            instr_ready = 1'b0;
            {Jump, BEQ, BNE, Zero} = 4'b0000;
            wait_cnt    = 0;
            hold_cnt    = 0;
        end else begin
            if (force_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (imem_req) begin
                bit give;
                if (n_fetch >= N_DIR) give = ($urandom_range(0, 2) == 0);
                else                  give = (wait_cnt >= lat_s[n_fetch]);
                if (give) begin
                    imem_ack = 1'b1;
                    if (n_fetch >= N_DIR) imem_rdata = $urandom;
                    else                  imem_rdata = data_s[n_fetch];
                    fetch_addr.push_back(imem_addr);
                    fetch_cyc.push_back(cyc);
                    n_fetch++;
                    wait_cnt = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wait_cnt++;
                end
            end else begin
                imem_ack   = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end

            if (instr_valid) begin
                idx = n_fetch - 1;
                if (idx >= N_DIR) begin
                    instr_ready = 1'($urandom_range(0, 1));
                    {Jump, BEQ, BNE, Zero} = 4'($urandom);
                end else begin
                    instr_ready = (hold_cnt >= rdy_s[idx]);
                    {Jump, BEQ, BNE, Zero} = rd_s[idx];
                end
                hold_cnt++;
            end else begin
                hold_cnt    = 0;
                instr_ready = 1'($urandom_range(0, 1));
                {Jump, BEQ, BNE, Zero} = 4'($urandom);
            end
        end
    end

    // Reference next-PC rules written as plain arithmetic.
    function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [31:0] ins,
                                               input logic j, input logic beq, input logic bne, input logic z);
        logic [31:0]        seq;
        logic signed [31:0] off;
        seq = p + 32'd4;
        off = signed'(ins[15:0]);
        off = off * 4;
        if (j)                            return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
        else if ((beq && z) || (bne && !z)) return seq + off;
        else                              return seq;
    endfunction

    function automatic logic [31:0] ref_redir(input logic j, input logic beq, input logic bne, input logic z);
        return {31'b0, j || (beq && z) || (bne && !z)};
    endfunction

    // Transaction-level model: started -> waiting for memory -> holding -> accepted.
    logic        m_started = 1'b0;
    logic        m_req = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_icnt = '0;
    logic [31:0] m_rcnt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_req     <= 1'b0;
            m_valid   <= 1'b0;
            m_pc      <= 32'h0000_0000;
            m_instr   <= '0;
            m_icnt    <= '0;
            m_rcnt    <= '0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_req     <= 1'b1;
        end else if (m_req) begin
            if (imem_ack) begin
                m_instr <= imem_rdata;
                m_valid <= 1'b1;
                m_req   <= 1'b0;
            end
        end else if (m_valid && instr_ready) begin
            m_pc    <= ref_target(m_pc, m_instr, Jump, BEQ, BNE, Zero);
            m_rcnt  <= m_rcnt + ref_redir(Jump, BEQ, BNE, Zero);
            m_icnt  <= m_icnt + 32'd1;
            m_valid <= 1'b0;
            m_req   <= 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req) check("imem_addr", imem_addr, m_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        check("instr", instr, m_instr);
        check("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
`ifdef FETCH_PERF_CNT_EN
        check("instr_count", instr_count, m_icnt);
        check("redirect_count", redirect_count, m_rcnt);
`else
        check("instr_count", instr_count, 32'd0);
        check("redirect_count", redirect_count, 32'd0);
`endif
    end

    initial begin
        int k;
        for (int i = 0; i < N_DIR; i++) begin
            data_s[i] = $urandom;
            lat_s[i]  = 0;
            rdy_s[i]  = 0;
            rd_s[i]   = 4'b0000;
        end
        data_s[0]  = 32'h8C08_0004;
        data_s[4]  = 32'h1000_FFFF;  rd_s[4]  = 4'b0101;
        data_s[5]  = 32'h1000_FFFF;  rd_s[5]  = 4'b0100;
        data_s[6]  = 32'h1000_FFFE;  rd_s[6]  = 4'b0101;
        data_s[7]  = 32'h1400_0003;  rd_s[7]  = 4'b0010;
        data_s[8]  = 32'h0800_0010;  rd_s[8]  = 4'b1000;
        lat_s[9]   = 5;              rdy_s[9] = 4;
        data_s[10] = 32'h1000_FFEB;  rd_s[10] = 4'b0101;
        data_s[13] = 32'h1400_0005;  rd_s[13] = 4'b0011;
        data_s[14] = 32'h8C08_0004;
        data_s[15] = 32'h2002_0001;  lat_s[15] = 8;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        @(posedge clk); #1;
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0000_0000);
        check("first_not_valid", {31'b0, instr_valid}, 32'd0);
        @(posedge clk); #1;
        check("first_valid", {31'b0, instr_valid}, 32'd1);
        check("first_opcode", {26'b0, opcode}, {26'b0, 6'b100011});

        k = 0;
        while (k < 1000 && !(n_fetch >= 15 && imem_req)) begin
            @(posedge clk); #1;
            k++;
        end
        check("dir_progress", {31'b0, (n_fetch >= 15 && imem_req)}, 32'd1);
        for (int i = 0; i < 15; i++)
            check($sformatf("fetch_addr%0d", i), fetch_addr[i], exp_addr[i]);
        check("cpi_0", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd2);
        check("cpi_1", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd2);
        check("ack_latency", 32'(fetch_cyc[9] - fetch_cyc[8]), 32'd7);
        check("ready_backpressure", 32'(fetch_cyc[10] - fetch_cyc[9]), 32'd6);
`ifdef FETCH_PERF_CNT_EN
        check("dir_instr_count", instr_count, 32'd15);
        check("dir_redirect_count", redirect_count, 32'd5);
`else
        check("dir_instr_count", instr_count, 32'd0);
        check("dir_redirect_count", redirect_count, 32'd0);
`endif

        // Reset while a fetch is outstanding, then present a stale ack right after release.
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_instr_count", instr_count, 32'd0);
        @(posedge clk); #2 force_ack = 1'b1;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rerelease_req", {31'b0, imem_req}, 32'd1);
        check("rerelease_addr", imem_addr, 32'h0000_0000);
        check("rerelease_valid", {31'b0, instr_valid}, 32'd0);
        check("rerelease_instr", instr, 32'd0);
        force_ack = 1'b0;

        k = 0;
        while (k < 100 && !instr_valid) begin
            @(posedge clk); #1;
            k++;
        end
        check("restart_valid", {31'b0, instr_valid}, 32'd1);
        check("restart_addr", fetch_addr[15], 32'h0000_0000);
        check("late_ack_ignored", instr, 32'h2002_0001);

        k = 0;
        while (k < 20000 && n_fetch < N_DIR + RAND_N) begin
            @(posedge clk); #1;
            k++;
        end
        check("rand_progress", {31'b0, (n_fetch >= N_DIR + RAND_N)}, 32'd1);
        repeat (4) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Single-issue instruction fetch stage holding the program counter, issuing word reads to instruction memory and presenting one instruction at a time to the decode/control stage. It sits directly upstream of the main control decoder: `opcode` feeds the decoder's 6-bit instruction input. The decoder's `Jump`, `BEQ`, `BNE` outputs and the ALU `Zero` flag return to this block to select the next PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request to instruction memory (registered).
- `imem_addr`  out  32  read address; equals `pc` whenever `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr` and `opcode` hold a fetched instruction.
- `instr_ready`  in  1  consumer accepts the held instruction; redirect inputs are sampled in the same cycle.
- `instr`  out  32  held instruction word.
- `opcode`  out  6  `instr[31:26]`, to the control decoder.
- `pc`  out  32  address of the held/in-flight instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `Jump`, `BEQ`, `BNE`  in  1 each  decoder outputs for the held instruction.
- `Zero`  in  1  ALU zero flag for the held instruction.
- `instr_count`  out  32  accepted-instruction counter (see Configuration).
- `redirect_count`  out  32  taken jump/branch counter (see Configuration).

## Operation
- FSM states: IDLE, FETCH, HOLD.
- Reset: state=IDLE, `pc`=RESET_PC, `imem_req`=0, `instr_valid`=0, `instr`=0, both counters 0.
- IDLE: on the first edge after reset release, go to FETCH and set `imem_req`=1.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, both held stable. On an edge with `imem_ack`=1: `instr`<=`imem_rdata`, `instr_valid`<=1, `imem_req`<=0, go to HOLD.
- HOLD: `instr`, `pc` and `instr_valid` are held stable. On an edge with `instr_ready`=1: `pc`<=next_pc, `instr_valid`<=0, `imem_req`<=1, go to FETCH.
- next_pc selection, evaluated in the accept cycle, priority top-down:
  - `Jump`=1: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - `BEQ`=1 and `Zero`=1: `pc_plus4` + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - `BNE`=1 and `Zero`=0: same branch target.
  - Otherwise: `pc_plus4`.
- All PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. Negative offsets wrap the same way.
- `imem_ack` outside FETCH is ignored. `instr_ready` outside HOLD is ignored. Redirect inputs are ignored except in the accept cycle.
- Reset asserted mid-operation immediately forces all outputs to their reset values. Any outstanding memory response is discarded.

## Timing
- `imem_req` rises one cycle after reset release.
- Memory latency is unbounded; FETCH waits indefinitely for `imem_ack`.
- `instr_valid` rises on the edge that samples `imem_ack`.
- Minimum of 2 cycles per instruction: ack in the first FETCH cycle, ready in the first HOLD cycle.
- A new `imem_req`/`imem_addr` carrying the redirected PC appears the cycle after the accept.
- `opcode` changes only on the edge that sets `instr_valid`.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `instr_count` increments on every HOLD accept.
  - `redirect_count` increments on every accept where next_pc came from the Jump or taken-branch path.
  - Both counters are 32 bits, wrap to 0, and are cleared by reset.
- `FETCH_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter registers are built. Fetch behaviour is identical.

## Test plan
- Reset, then release, memory acks after 1 cycle: `imem_addr`=0x0 and `imem_req`=1 one cycle after release. `instr_valid`=1 with `opcode`=6'b100011 for `imem_rdata`=0x8C080004.
- Sequential stream with `instr_ready`=1 whenever valid: fetch addresses 0x0, 0x4, 0x8 at one instruction per 2 cycles. Under the macro, `instr_count`=3 after three accepts.
- BEQ at pc=0x10, offset 0xFFFF, `Zero`=1 -> next fetch 0x10. Same with `Zero`=0 -> 0x14. BNE at 0x10, offset 0x0003, `Zero`=0 -> 0x20.
- Jump at pc=0x4000_0000, `instr[25:0]`=0x0000010 -> next fetch 0x4000_0040. Under the macro, `redirect_count` increments by 1.
- Backpressure and latency: `imem_ack` delayed 5 cycles -> address stable throughout. `instr_ready` low for 4 cycles -> `instr` unchanged and no new request issued.
- Reset mid-FETCH with a late ack arriving after re-release: outputs return to reset values, the late ack is ignored, and fetch restarts at RESET_PC. PC 0xFFFF_FFFC not-taken -> next fetch 0x0.
